// File: rtl/gcd_pkg.sv
// Shared types for the GCD sequencer, the ALU it drives and the gcd_top wrapper.
// Holds the ALU opcode encoding, the sequencer state encoding and the datapath width.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_AND  = 3'b001,
        ALU_OR   = 3'b010,
        ALU_NOT  = 3'b011,
        ALU_ADD  = 3'b100,
        ALU_SUB  = 3'b101,
        ALU_INC  = 3'b110,
        ALU_DEC  = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SUB_A = 3'd2,
        ST_SUB_B = 3'd3,
        ST_DONE  = 3'd4
    } gcd_state_t;

endpackage

// File: rtl/gcd_ctrl.sv
// GCD sequencer: computes GCD(A,B) by repeated larger-minus-smaller subtraction,
// borrowing an external ALU for each subtraction and writing alu_dout back.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int WIDTH    = GCD_WIDTH,
    parameter int MAX_ITER = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a_in,
    input  logic [WIDTH-1:0] i_b_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [WIDTH-1:0] o_result,
    output logic [7:0]       o_iter_count,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [2:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_dout
);

    localparam logic [7:0] MAX_ITER_C = 8'(MAX_ITER);

    gcd_state_t       r_state;
    gcd_state_t       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [7:0]       r_iter;
    logic             r_error;
    alu_op_t          w_alu_op;

    logic w_a_zero;
    logic w_b_zero;
    logic w_a_eq_b;
    logic w_a_gt_b;
    logic w_at_limit;
    logic w_finish;

    assign w_a_zero   = (r_a == {WIDTH{1'b0}});
    assign w_b_zero   = (r_b == {WIDTH{1'b0}});
    assign w_a_eq_b   = (r_a == r_b);
    assign w_a_gt_b   = (r_a > r_b);
    assign w_at_limit = (r_iter == MAX_ITER_C);
    // The limit test sits before every subtraction, so r_iter can never pass MAX_ITER.
    assign w_finish   = w_a_zero | w_b_zero | w_a_eq_b | w_at_limit;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next_state = ST_CHECK;
                else         w_next_state = ST_IDLE;
            end
            ST_CHECK: begin
                if (w_finish)      w_next_state = ST_DONE;
                else if (w_a_gt_b) w_next_state = ST_SUB_A;
                else               w_next_state = ST_SUB_B;
            end
            ST_SUB_A: w_next_state = ST_CHECK;
            ST_SUB_B: w_next_state = ST_CHECK;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Working registers, iteration counter and held result/error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_iter   <= 8'd0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a_in;
                        r_b     <= i_b_in;
                        r_iter  <= 8'd0;
                        r_error <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_a_zero) begin
                        r_result <= r_b;
                    end else if (w_b_zero) begin
                        r_result <= r_a;
                    end else if (w_a_eq_b) begin
                        r_result <= r_a;
                    end else if (w_at_limit) begin
                        r_error  <= 1'b1;
                        r_result <= {WIDTH{1'b0}};
                    end
                end
                ST_SUB_A: begin
                    r_a    <= i_alu_dout;
                    r_iter <= r_iter + 8'd1;
                end
                ST_SUB_B: begin
                    r_b    <= i_alu_dout;
                    r_iter <= r_iter + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // ALU operand/opcode drive and status flags, decoded from the current state
    always_comb begin
        w_alu_op = ALU_PASS;
        o_alu_a  = r_a;
        o_alu_b  = r_b;
        case (r_state)
            ST_SUB_A: begin
                w_alu_op = ALU_SUB;
            end
            ST_SUB_B: begin
                w_alu_op = ALU_SUB;
                o_alu_a  = r_b;
                o_alu_b  = r_a;
            end
            default: begin
                w_alu_op = ALU_PASS;
            end
        endcase
    end

    assign o_alu_op     = w_alu_op;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_result     = r_result;
    assign o_iter_count = r_iter;
    assign o_error      = r_error;

endmodule
